// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants for the decode stage.
//   icode values HALT..POPQ, register ids (RSP, RNONE), status codes,
//   the NOP-bubble field values, and the source/destination register
//   selection helpers used by decode.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] R_RSP  = 4'h4;
   localparam logic [3:0] R_NONE = 4'hF;

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_ADR = 3'd2;
   localparam logic [2:0] S_INS = 3'd3;
   localparam logic [2:0] S_HLT = 3'd4;

   localparam logic [2:0] BUB_STAT  = S_AOK;
   localparam logic [3:0] BUB_ICODE = I_NOP;
   localparam logic [3:0] BUB_IFUN  = 4'h0;
   localparam logic [3:0] BUB_REG   = R_NONE;

   function automatic logic [3:0] sel_src_a(input logic [3:0] icode, input logic [3:0] ra);
      case (icode)
         I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: return ra;
         I_POPQ, I_RET:                      return R_RSP;
         default:                            return R_NONE;
      endcase
   endfunction

   function automatic logic [3:0] sel_src_b(input logic [3:0] icode, input logic [3:0] rb);
      case (icode)
         I_OPQ, I_RMMOVQ, I_MRMOVQ:        return rb;
         I_PUSHQ, I_POPQ, I_CALL, I_RET:   return R_RSP;
         default:                          return R_NONE;
      endcase
   endfunction

   function automatic logic [3:0] sel_dst_e(input logic [3:0] icode, input logic [3:0] rb);
      case (icode)
         I_RRMOVQ, I_IRMOVQ, I_OPQ:        return rb;
         I_PUSHQ, I_POPQ, I_CALL, I_RET:   return R_RSP;
         default:                          return R_NONE;
      endcase
   endfunction

   function automatic logic [3:0] sel_dst_m(input logic [3:0] icode, input logic [3:0] ra);
      case (icode)
         I_MRMOVQ, I_POPQ: return ra;
         default:          return R_NONE;
      endcase
   endfunction

endpackage

// File: rtl/y86_regfile.sv
// y86_regfile: 15 x DATA_W architectural register file.
//   clk_i, rst_n_i        : clock, synchronous active-low reset (clears all)
//   src_a_i / val_a_o     : async read port A (id F reads 0)
//   src_b_i / val_b_o     : async read port B (id F reads 0)
//   dst_e_i / val_e_i     : write port E (id F = no write)
//   dst_m_i / val_m_i     : write port M (id F = no write), wins over E
//   dbg_addr_i/dbg_data_o : extra async read port, only with DECODE_DEBUG_EN
import y86_pkg::*;

module y86_regfile #(
   parameter int DATA_W  = 64,
   parameter int REG_NUM = 15
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [3:0]        src_a_i,
   input  logic [3:0]        src_b_i,
   output logic [DATA_W-1:0] val_a_o,
   output logic [DATA_W-1:0] val_b_o,
   input  logic [3:0]        dst_e_i,
   input  logic [DATA_W-1:0] val_e_i,
   input  logic [3:0]        dst_m_i,
`ifdef DECODE_DEBUG_EN
   input  logic [DATA_W-1:0] val_m_i,
   input  logic [3:0]        dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o
`else
   input  logic [DATA_W-1:0] val_m_i
`endif
);

   logic [DATA_W-1:0] regs [REG_NUM];

   // Port M is assigned last so it overrides port E on a shared id (popq %rsp).
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      end else begin
         if (dst_e_i != R_NONE) regs[dst_e_i] <= val_e_i;
         if (dst_m_i != R_NONE) regs[dst_m_i] <= val_m_i;
      end
   end

   assign val_a_o = (src_a_i == R_NONE) ? '0 : regs[src_a_i];
   assign val_b_o = (src_b_i == R_NONE) ? '0 : regs[src_b_i];

`ifdef DECODE_DEBUG_EN
   assign dbg_data_o = (dbg_addr_i == R_NONE) ? '0 : regs[dbg_addr_i];
`endif

endmodule

// File: rtl/decode_stage.sv
// decode_stage: Y86-64 decode stage (D pipeline register, register file,
// source/destination selection and valA/valB forwarding).
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   D_stall_i, D_bubble_i   : D register hold / NOP-bubble insert (stall wins)
//   f_*                     : fetch outputs captured into the D register
//   e_/M_/W_/m_* forwarding : later-stage destinations and values
//   W_dstE/W_valE/W_dstM/W_valM also drive the register file write ports
//   D_icode_o, d_*          : decoded fields to the E register and hazard unit
// Optional macro DECODE_DEBUG_EN adds dbg_addr_i / dbg_data_o, an async
// register peek port that does not affect the pipeline.
import y86_pkg::*;

module decode_stage #(
   parameter int DATA_W  = 64,
   parameter int REG_NUM = 15
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              D_stall_i,
   input  logic              D_bubble_i,
   input  logic [2:0]        f_stat_i,
   input  logic [3:0]        f_icode_i,
   input  logic [3:0]        f_ifun_i,
   input  logic [3:0]        f_rA_i,
   input  logic [3:0]        f_rB_i,
   input  logic [DATA_W-1:0] f_valC_i,
   input  logic [DATA_W-1:0] f_valP_i,
   input  logic [3:0]        e_dstE_i,
   input  logic [DATA_W-1:0] e_valE_i,
   input  logic [3:0]        M_dstE_i,
   input  logic [DATA_W-1:0] M_valE_i,
   input  logic [3:0]        M_dstM_i,
   input  logic [DATA_W-1:0] m_valM_i,
   input  logic [3:0]        W_dstE_i,
   input  logic [DATA_W-1:0] W_valE_i,
   input  logic [3:0]        W_dstM_i,
   input  logic [DATA_W-1:0] W_valM_i,
`ifdef DECODE_DEBUG_EN
   input  logic [3:0]        dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o,
`endif
   output logic [3:0]        D_icode_o,
   output logic [2:0]        d_stat_o,
   output logic [3:0]        d_icode_o,
   output logic [3:0]        d_ifun_o,
   output logic [DATA_W-1:0] d_valC_o,
   output logic [DATA_W-1:0] d_valA_o,
   output logic [DATA_W-1:0] d_valB_o,
   output logic [3:0]        d_dstE_o,
   output logic [3:0]        d_dstM_o,
   output logic [3:0]        d_srcA_o,
   output logic [3:0]        d_srcB_o
);

   logic [2:0]        D_stat;
   logic [3:0]        D_icode, D_ifun, D_rA, D_rB;
   logic [DATA_W-1:0] D_valC, D_valP;
   logic [DATA_W-1:0] rf_val_a, rf_val_b;
   logic [3:0]        src_a, src_b;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || (!D_stall_i && D_bubble_i)) begin
         D_stat  <= BUB_STAT;
         D_icode <= BUB_ICODE;
         D_ifun  <= BUB_IFUN;
         D_rA    <= BUB_REG;
         D_rB    <= BUB_REG;
         D_valC  <= '0;
         D_valP  <= '0;
      end else if (!D_stall_i) begin
         D_stat  <= f_stat_i;
         D_icode <= f_icode_i;
         D_ifun  <= f_ifun_i;
         D_rA    <= f_rA_i;
         D_rB    <= f_rB_i;
         D_valC  <= f_valC_i;
         D_valP  <= f_valP_i;
      end
   end

   assign src_a = sel_src_a(D_icode, D_rA);
   assign src_b = sel_src_b(D_icode, D_rB);

   y86_regfile #(.DATA_W(DATA_W), .REG_NUM(REG_NUM)) u_regfile (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .src_a_i    (src_a),
      .src_b_i    (src_b),
      .val_a_o    (rf_val_a),
      .val_b_o    (rf_val_b),
      .dst_e_i    (W_dstE_i),
      .val_e_i    (W_valE_i),
      .dst_m_i    (W_dstM_i),
`ifdef DECODE_DEBUG_EN
      .val_m_i    (W_valM_i),
      .dbg_addr_i (dbg_addr_i),
      .dbg_data_o (dbg_data_o)
`else
      .val_m_i    (W_valM_i)
`endif
   );

   // Youngest producer first; RNONE sources are excluded so an idle F
   // destination in a later stage never forwards.
   always_comb begin
      d_valA_o = rf_val_a;
      if (D_icode == I_CALL || D_icode == I_JXX)        d_valA_o = D_valP;
      else if (src_a != R_NONE && src_a == e_dstE_i)    d_valA_o = e_valE_i;
      else if (src_a != R_NONE && src_a == M_dstM_i)    d_valA_o = m_valM_i;
      else if (src_a != R_NONE && src_a == M_dstE_i)    d_valA_o = M_valE_i;
      else if (src_a != R_NONE && src_a == W_dstM_i)    d_valA_o = W_valM_i;
      else if (src_a != R_NONE && src_a == W_dstE_i)    d_valA_o = W_valE_i;
   end

   always_comb begin
      d_valB_o = rf_val_b;
      if (src_b != R_NONE && src_b == e_dstE_i)         d_valB_o = e_valE_i;
      else if (src_b != R_NONE && src_b == M_dstM_i)    d_valB_o = m_valM_i;
      else if (src_b != R_NONE && src_b == M_dstE_i)    d_valB_o = M_valE_i;
      else if (src_b != R_NONE && src_b == W_dstM_i)    d_valB_o = W_valM_i;
      else if (src_b != R_NONE && src_b == W_dstE_i)    d_valB_o = W_valE_i;
   end

   assign D_icode_o = D_icode;
   assign d_stat_o  = D_stat;
   assign d_icode_o = D_icode;
   assign d_ifun_o  = D_ifun;
   assign d_valC_o  = D_valC;
   assign d_srcA_o  = src_a;
   assign d_srcB_o  = src_b;
   assign d_dstE_o  = sel_dst_e(D_icode, D_rB);
   assign d_dstM_o  = sel_dst_m(D_icode, D_rA);

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          D_stall, D_bubble;
   logic [2:0]    f_stat;
   logic [3:0]    f_icode, f_ifun, f_rA, f_rB;
   logic [DW-1:0] f_valC, f_valP;
   logic [3:0]    e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
   logic [DW-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
   logic [3:0]    D_icode;
   logic [2:0]    d_stat;
   logic [3:0]    d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
   logic [DW-1:0] d_valC, d_valA, d_valB;
`ifdef DECODE_DEBUG_EN
   logic [3:0]    dbg_addr = 4'hF;
   logic [DW-1:0] dbg_data;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string         tag;
      logic [2:0]    stat;
      logic [3:0]    icode, ifun;
      logic [DW-1:0] valc, vala, valb;
      logic [3:0]    dste, dstm, srca, srcb;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   decode_stage #(.DATA_W(DW), .REG_NUM(15)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .D_stall_i  (D_stall),
      .D_bubble_i (D_bubble),
      .f_stat_i   (f_stat),
      .f_icode_i  (f_icode),
      .f_ifun_i   (f_ifun),
      .f_rA_i     (f_rA),
      .f_rB_i     (f_rB),
      .f_valC_i   (f_valC),
      .f_valP_i   (f_valP),
      .e_dstE_i   (e_dstE),
      .e_valE_i   (e_valE),
      .M_dstE_i   (M_dstE),
      .M_valE_i   (M_valE),
      .M_dstM_i   (M_dstM),
      .m_valM_i   (m_valM),
      .W_dstE_i   (W_dstE),
      .W_valE_i   (W_valE),
      .W_dstM_i   (W_dstM),
      .W_valM_i   (W_valM),
`ifdef DECODE_DEBUG_EN
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data),
`endif
      .D_icode_o  (D_icode),
      .d_stat_o   (d_stat),
      .d_icode_o  (d_icode),
      .d_ifun_o   (d_ifun),
      .d_valC_o   (d_valC),
      .d_valA_o   (d_valA),
      .d_valB_o   (d_valB),
      .d_dstE_o   (d_dstE),
      .d_dstM_o   (d_dstM),
      .d_srcA_o   (d_srcA),
      .d_srcB_o   (d_srcB)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [DW-1:0] vc, input logic [DW-1:0] vp);
      f_stat = st; f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
   endtask

   task automatic push(input string tag, input logic [2:0] st, input logic [3:0] ic,
                       input logic [3:0] fn, input logic [DW-1:0] vc,
                       input logic [DW-1:0] va, input logic [DW-1:0] vb,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [3:0] sa, input logic [3:0] sbb);
      exp_t e;
      e.tag = tag; e.stat = st; e.icode = ic; e.ifun = fn; e.valc = vc;
      e.vala = va; e.valb = vb; e.dste = de; e.dstm = dm; e.srca = sa; e.srcb = sbb;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      n_assert++;
      assert (sb.size() > 0)
      else begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ".stat"},   DW'(d_stat),  DW'(e.stat));
      chk({e.tag, ".icode"},  DW'(d_icode), DW'(e.icode));
      chk({e.tag, ".Dicode"}, DW'(D_icode), DW'(e.icode));
      chk({e.tag, ".ifun"},   DW'(d_ifun),  DW'(e.ifun));
      chk({e.tag, ".valC"},   d_valC,       e.valc);
      chk({e.tag, ".valA"},   d_valA,       e.vala);
      chk({e.tag, ".valB"},   d_valB,       e.valb);
      chk({e.tag, ".dstE"},   DW'(d_dstE),  DW'(e.dste));
      chk({e.tag, ".dstM"},   DW'(d_dstM),  DW'(e.dstm));
      chk({e.tag, ".srcA"},   DW'(d_srcA),  DW'(e.srca));
      chk({e.tag, ".srcB"},   DW'(d_srcB),  DW'(e.srcb));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fwd();
      e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
      e_valE = '0;   M_valE = '0;   m_valM = '0;   W_valE = '0;   W_valM = '0;
   endtask

   initial begin
      rst_n = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
      clear_fwd();
      fetch(3'd1, 4'h0, 4'h0, 4'hF, 4'hF, '0, '0);

      // reset: bubble in D, registers cleared
      push("reset", 3'd1, 4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
      tick(); tick();
      rst_n = 1'b1;
      pop_check();

      // irmovq $0x55, %rdx
      fetch(3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h55, 64'h0A);
      push("irmovq", 3'd1, 4'h3, 4'h0, 64'h55, 0, 0, 4'h2, 4'hF, 4'hF, 4'hF);
      tick(); pop_check();

      // write r3=0x10 through port E while fetching rrmovq %rbx,%rbp
      W_dstE = 4'h3; W_valE = 64'h10;
      fetch(3'd1, 4'h2, 4'h0, 4'h3, 4'h5, 64'h0, 64'h0C);
      push("rrmovq_rf", 3'd1, 4'h2, 4'h0, 0, 64'h10, 0, 4'h5, 4'hF, 4'h3, 4'hF);
      tick();
      clear_fwd();
      pop_check();

      // e stage beats M stage
      e_dstE = 4'h3; e_valE = 64'h99; M_dstE = 4'h3; M_valE = 64'h77;
      push("fwd_e", 3'd1, 4'h2, 4'h0, 0, 64'h99, 0, 4'h5, 4'hF, 4'h3, 4'hF);
      tick(); pop_check();

      // m_valM beats M_valE
      e_dstE = 4'hF; M_dstM = 4'h3; m_valM = 64'h88;
      push("fwd_mM", 3'd1, 4'h2, 4'h0, 0, 64'h88, 0, 4'h5, 4'hF, 4'h3, 4'hF);
      tick(); pop_check();
      clear_fwd();

      // opq with valB forwarded from W_valM (also written into r6)
      W_dstM = 4'h6; W_valM = 64'h33;
      fetch(3'd1, 4'h6, 4'h0, 4'h3, 4'h6, 64'h0, 64'h0E);
      push("opq_fwdW", 3'd1, 4'h6, 4'h0, 0, 64'h10, 64'h33, 4'h6, 4'hF, 4'h3, 4'h6);
      tick(); pop_check();
      clear_fwd();

      // popq %rsp: both write ports target r4, port M must win
      W_dstE = 4'h4; W_valE = 64'h100; W_dstM = 4'h4; W_valM = 64'h200;
      fetch(3'd1, 4'hB, 4'h0, 4'h4, 4'hF, 64'h0, 64'h10);
      push("popq_rsp", 3'd1, 4'hB, 4'h0, 0, 64'h200, 64'h200, 4'h4, 4'h4, 4'h4, 4'h4);
      tick();
      clear_fwd();
      pop_check();

      // call: valA = valP
      fetch(3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h80, 64'h40);
      push("call", 3'd1, 4'h8, 4'h0, 64'h80, 64'h40, 64'h200, 4'h4, 4'hF, 4'hF, 4'h4);
      tick(); pop_check();

      // stall: D holds the call
      D_stall = 1'b1;
      fetch(3'd2, 4'h3, 4'h1, 4'hF, 4'h7, 64'hAB, 64'hCD);
      push("stall", 3'd1, 4'h8, 4'h0, 64'h80, 64'h40, 64'h200, 4'h4, 4'hF, 4'hF, 4'h4);
      tick(); pop_check();
      D_stall = 1'b0;

      // bubble
      D_bubble = 1'b1;
      push("bubble", 3'd1, 4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
      tick(); pop_check();
      D_bubble = 1'b0;

      // jXX: valA = valP
      fetch(3'd1, 4'h7, 4'h3, 4'hF, 4'hF, 64'h300, 64'h77);
      push("jxx", 3'd1, 4'h7, 4'h3, 64'h300, 64'h77, 0, 4'hF, 4'hF, 4'hF, 4'hF);
      tick(); pop_check();

      // opq r3,r4 from the register file
      fetch(3'd1, 4'h6, 4'h1, 4'h3, 4'h4, 64'h0, 64'h79);
      push("opq_rf", 3'd1, 4'h6, 4'h1, 0, 64'h10, 64'h200, 4'h4, 4'hF, 4'h3, 4'h4);
      tick(); pop_check();

      // stall and bubble together: stall wins
      D_stall = 1'b1; D_bubble = 1'b1;
      fetch(3'd4, 4'h0, 4'h0, 4'h1, 4'h1, 64'hFF, 64'hEE);
      push("stall_bub", 3'd1, 4'h6, 4'h1, 0, 64'h10, 64'h200, 4'h4, 4'hF, 4'h3, 4'h4);
      tick(); pop_check();
      D_stall = 1'b0; D_bubble = 1'b0;

      // unknown icode: no register selection, fields pass through
      fetch(3'd3, 4'hC, 4'h5, 4'h1, 4'h2, 64'h123, 64'h80);
      push("bad_icode", 3'd3, 4'hC, 4'h5, 64'h123, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
      tick(); pop_check();

      // reset mid-stream
      rst_n = 1'b0;
      fetch(3'd1, 4'h6, 4'h0, 4'h3, 4'h4, 64'h0, 64'h90);
      push("reset_mid", 3'd1, 4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
      tick(); pop_check();
      rst_n = 1'b1;

      // registers 3 and 4 were cleared by the reset
      push("post_reset", 3'd1, 4'h6, 4'h0, 0, 0, 0, 4'h4, 4'hF, 4'h3, 4'h4);
      tick(); pop_check();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
